// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter sharing the UART TX FIFO write port.
// Channel 0 carries ALU results, channel 1 carries debug/echo traffic.
module uart_tx_arbiter #(
    parameter int NB_DATA = 8,
    parameter int MAX_LEN = 8,
    parameter int NB_CNT  = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_req0_valid,
    input  logic [NB_DATA-1:0] i_req0_data,
    input  logic               i_req0_last,
    output logic               o_req0_ready,
    input  logic               i_req1_valid,
    input  logic [NB_DATA-1:0] i_req1_data,
    input  logic               i_req1_last,
    output logic               o_req1_ready,
    input  logic               i_tx_full,
    output logic               o_wr,
    output logic [NB_DATA-1:0] o_w_data,
    output logic [1:0]         o_grant,
    output logic               o_busy,
    output logic               o_trunc
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [1:0]          grant;
    logic [1:0]          grant_nx;
    logic                rr_ptr;
    logic                rr_nx;
    logic [NB_CNT-1:0]   cnt;
    logic [NB_CNT-1:0]   cnt_nx;
    logic                trunc_q;
    logic                trunc_nx;

    logic                busy;
    logic                xfer0;
    logic                xfer1;
    logic                xfer;
    logic                sel_last;
    logic                at_max;

    assign busy         = (state == BUSY);
    assign o_req0_ready = busy & grant[0] & ~i_tx_full;
    assign o_req1_ready = busy & grant[1] & ~i_tx_full;
    assign xfer0        = i_req0_valid & o_req0_ready;
    assign xfer1        = i_req1_valid & o_req1_ready;
    assign xfer         = xfer0 | xfer1;
    assign at_max       = (cnt == NB_CNT'(MAX_LEN - 1));

    assign o_wr    = xfer;
    assign o_grant = grant;
    assign o_busy  = busy;
    assign o_trunc = trunc_q;

    always_comb begin
        o_w_data = '0;
        sel_last = 1'b0;
        unique case (1'b1)
            grant[0]: begin
                o_w_data = i_req0_data;
                sel_last = i_req0_last;
            end
            grant[1]: begin
                o_w_data = i_req1_data;
                sel_last = i_req1_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        rr_nx    = rr_ptr;
        cnt_nx   = cnt;
        trunc_nx = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (i_req0_valid & i_req1_valid) begin
                    grant_nx = rr_ptr ? 2'b10 : 2'b01;
                    state_nx = BUSY;
                end else if (i_req0_valid) begin
                    grant_nx = 2'b01;
                    state_nx = BUSY;
                end else if (i_req1_valid) begin
                    grant_nx = 2'b10;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    cnt_nx = cnt + NB_CNT'(1);
                    // A message ends on its last byte or is cut at MAX_LEN
                    if (sel_last | at_max) begin
                        state_nx = IDLE;
                        grant_nx = 2'b00;
                        rr_nx    = grant[0];
                        trunc_nx = ~sel_last;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = 2'b00;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state   <= IDLE;
            grant   <= 2'b00;
            rr_ptr  <= 1'b0;
            cnt     <= '0;
            trunc_q <= 1'b0;
        end else begin
            state   <= state_nx;
            grant   <= grant_nx;
            rr_ptr  <= rr_nx;
            cnt     <= cnt_nx;
            trunc_q <= trunc_nx;
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX FIFO write port between two message sources.
  - Channel 0 carries the ALU result path from the rx interface.
  - Channel 1 carries the debug/echo path.
- Arbitrates per message, not per byte: once a channel is granted, all of its bytes reach the FIFO contiguously.
- Uses round-robin fairness between messages and enforces a maximum message length.
- Sits between the requesters and the fifo_tx_unit write side (wr, w_data, full).

Parameters:
- NB_DATA, 8, byte width of each data channel and of the FIFO word.
- MAX_LEN, 8, maximum bytes per message; a message is force-terminated on its MAX_LEN-th byte. Legal range 1..255.
- NB_CNT, 8, width of the in-message byte counter; must satisfy 2^NB_CNT > MAX_LEN.

Ports:
- i_clk  in  1  system clock; all state is on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req0_valid  in  1  channel 0 byte valid.
- i_req0_data  in  NB_DATA  channel 0 byte.
- i_req0_last  in  1  channel 0 byte is the final byte of its message.
- o_req0_ready  out  1  channel 0 byte accepted this cycle when valid is also high.
- i_req1_valid  in  1  channel 1 byte valid.
- i_req1_data  in  NB_DATA  channel 1 byte.
- i_req1_last  in  1  channel 1 byte is the final byte of its message.
- o_req1_ready  out  1  channel 1 byte accepted this cycle when valid is also high.
- i_tx_full  in  1  TX FIFO full flag.
- o_wr  out  1  FIFO write strobe.
- o_w_data  out  NB_DATA  FIFO write data.
- o_grant  out  2  one-hot current owner; 00 when idle.
- o_busy  out  1  a message is in progress.
- o_trunc  out  1  one-cycle pulse when a message is cut at MAX_LEN.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state=IDLE, grant=00, rr_ptr=0 (channel 0 preferred), cnt=0.
  - o_trunc=0.
  - o_wr, o_req*_ready, o_busy, o_grant all 0.
  - Reset mid-message drops the message silently; no partial flush.
- Transfer on channel k occurs when i_reqk_valid & o_reqk_ready.
- o_reqk_ready = (state==BUSY) & grant[k] & ~i_tx_full. This is combinational; the non-granted channel's ready is always 0.
- o_wr = transfer on the granted channel (combinational, same cycle).
- o_w_data = granted channel's data; 0 when no grant.
- IDLE state:
  - If only one valid is high, register grant to that channel.
  - If both are high, grant channel rr_ptr.
  - Go to BUSY next cycle. Arbitration latency is 1 cycle; no transfer occurs in IDLE.
  - cnt is cleared.
- BUSY state:
  - Each transfer increments cnt.
  - On a transfer with last=1: go to IDLE, grant←00, rr_ptr←other channel.
  - On a transfer with last=0 and cnt==MAX_LEN-1 (the MAX_LEN-th byte): go to IDLE, grant←00, rr_ptr←other channel, o_trunc=1 for one cycle (registered, the cycle after the transfer). The remaining bytes of that source start a new message when it is re-granted.
  - If valid drops mid-message, grant is held indefinitely. No timeout; the other channel waits.
  - If i_tx_full=1, ready=0 and nothing is written; the state holds.
- rr_ptr changes only at message completion. A single requesting channel may be re-granted back-to-back, with one idle cycle between its messages.
- o_busy = (state==BUSY). o_grant = grant register.
- MAX_LEN=1: every byte is its own message; o_trunc pulses on any byte with last=0.
- Throughput: 1 byte/cycle while granted, valid and not full.

Test Plan:
- Reset, then channel 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) with channel 1 idle:
  - Grant is 01 one cycle after valid.
  - o_wr is high 3 consecutive cycles with data 0x11,0x22,0x33.
  - Then idle, grant=00, rr_ptr=1.
- Both channels raise valid in the same cycle after reset; ch0 sends 0xA0,0xA1(last), ch1 sends 0xB0(last):
  - FIFO sequence is A0,A1,B0 with no interleaving.
  - A second simultaneous request afterward is served channel 0 first again, since rr_ptr returned to 0 after ch1 finished.
- i_tx_full asserted for 4 cycles mid-message of 0x01..0x04:
  - o_wr and ready are 0 during full.
  - Bytes resume in order with none lost or duplicated.
- MAX_LEN=8 and channel 1 streams 10 bytes 0x00..0x09 without last:
  - Bytes 0x00..0x07 are written, then o_trunc pulses once.
  - Grant goes to channel 0 if it is pending; otherwise ch1 is re-granted and 0x08,0x09 follow.
- i_reset driven low mid-message asynchronously (not on a clock edge):
  - All outputs go to 0 immediately.
  - After release, a new ch0 message arbitrates normally from rr_ptr=0.
- Granted channel drops valid for 5 cycles mid-message while ch1 is valid:
  - Grant stays with ch0.
  - o_req1_ready stays 0 throughout.
  - ch0 completes its message before ch1 starts.
